// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and operation codes for the execution unit
package alu_pkg;

    localparam int RS_TYPE_WIDTH = 5;
    localparam int ROB_WIDTH     = 4;

    typedef enum logic [RS_TYPE_WIDTH-1:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_ADDI  = 5'd10,
        ALU_SLTI  = 5'd11,
        ALU_SLTIU = 5'd12,
        ALU_XORI  = 5'd13,
        ALU_ORI   = 5'd14,
        ALU_ANDI  = 5'd15,
        ALU_SLLI  = 5'd16,
        ALU_SRLI  = 5'd17,
        ALU_SRAI  = 5'd18,
        ALU_BEQ   = 5'd19,
        ALU_BNE   = 5'd20,
        ALU_BLT   = 5'd21,
        ALU_BGE   = 5'd22,
        ALU_BLTU  = 5'd23,
        ALU_BGEU  = 5'd24,
        ALU_JALR  = 5'd25
    } alu_type_e;

    function automatic logic is_branch(input logic [RS_TYPE_WIDTH-1:0] t);
        return (t >= ALU_BEQ) && (t <= ALU_BGEU);
    endfunction

endpackage

// File: rtl/branch_comparator.sv
// rtl/branch_comparator.sv - combinational branch condition evaluation
module branch_comparator
    import alu_pkg::*;
(
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    input  logic [RS_TYPE_WIDTH-1:0] br_type,
    output logic                     taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            ALU_BEQ:  taken = (a == b);
            ALU_BNE:  taken = (a != b);
            ALU_BLT:  taken = ($signed(a) < $signed(b));
            ALU_BGE:  taken = ($signed(a) >= $signed(b));
            ALU_BLTU: taken = (a < b);
            ALU_BGEU: taken = (a >= b);
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered execution unit between RS and ROB
module alu
    import alu_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     alu_en,
    input  logic [ROB_WIDTH-1:0]     alu_rob_id,
    input  logic [31:0]              alu_data_j,
    input  logic [31:0]              alu_data_k,
    input  logic [31:0]              alu_imm,
    input  logic [RS_TYPE_WIDTH-1:0] alu_type,
    output logic                     alu_rdy,
    output logic [ROB_WIDTH-1:0]     alu_rob_id_out,
    output logic [31:0]              alu_result,
    output logic                     alu_set_jump_addr
);

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        taken;
    logic [31:0] result_d;
    logic        jump_d;

    assign a     = alu_data_j;
    assign b     = ((alu_type >= ALU_ADDI) && (alu_type <= ALU_SRAI)) ? alu_imm : alu_data_k;
    assign shamt = b[4:0];

    branch_comparator u_cmp (
        .a       (alu_data_j),
        .b       (alu_data_k),
        .br_type (alu_type),
        .taken   (taken)
    );

    always_comb begin
        result_d = 32'd0;
        jump_d   = 1'b0;
        case (alu_type)
            ALU_ADD, ALU_ADDI:   result_d = a + b;
            ALU_SUB:             result_d = a - b;
            ALU_SLL, ALU_SLLI:   result_d = a << shamt;
            ALU_SLT, ALU_SLTI:   result_d = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU, ALU_SLTIU: result_d = {31'd0, a < b};
            ALU_XOR, ALU_XORI:   result_d = a ^ b;
            ALU_SRL, ALU_SRLI:   result_d = a >> shamt;
            ALU_SRA, ALU_SRAI:   result_d = $signed(a) >>> shamt;
            ALU_OR, ALU_ORI:     result_d = a | b;
            ALU_AND, ALU_ANDI:   result_d = a & b;
            ALU_JALR: begin
                result_d = (a + alu_imm) & ~32'd1;
                jump_d   = 1'b1;
            end
            default: begin
                // Branch immediates already carry the target; undefined codes fall through to zero.
                if (is_branch(alu_type) && taken) begin
                    result_d = alu_imm;
                    jump_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_rdy           <= 1'b0;
            alu_rob_id_out    <= '0;
            alu_result        <= 32'd0;
            alu_set_jump_addr <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                alu_rdy           <= 1'b0;
                alu_set_jump_addr <= 1'b0;
            end else begin
                alu_rdy <= alu_en;
                if (alu_en) begin
                    alu_rob_id_out    <= alu_rob_id;
                    alu_result        <= result_d;
                    alu_set_jump_addr <= jump_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;
    import alu_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     flush;
    logic                     alu_en;
    logic [ROB_WIDTH-1:0]     alu_rob_id;
    logic [31:0]              alu_data_j;
    logic [31:0]              alu_data_k;
    logic [31:0]              alu_imm;
    logic [RS_TYPE_WIDTH-1:0] alu_type;
    logic                     alu_rdy;
    logic [ROB_WIDTH-1:0]     alu_rob_id_out;
    logic [31:0]              alu_result;
    logic                     alu_set_jump_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    alu dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .flush             (flush),
        .alu_en            (alu_en),
        .alu_rob_id        (alu_rob_id),
        .alu_data_j        (alu_data_j),
        .alu_data_k        (alu_data_k),
        .alu_imm           (alu_imm),
        .alu_type          (alu_type),
        .alu_rdy           (alu_rdy),
        .alu_rob_id_out    (alu_rob_id_out),
        .alu_result        (alu_result),
        .alu_set_jump_addr (alu_set_jump_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive(input logic [4:0] t, input logic [31:0] j, input logic [31:0] k,
                         input logic [31:0] imm, input logic [3:0] id);
        alu_en     = 1'b1;
        alu_type   = t;
        alu_data_j = j;
        alu_data_k = k;
        alu_imm    = imm;
        alu_rob_id = id;
    endtask

    task automatic run_op(input string tag, input logic [4:0] t, input logic [31:0] j,
                          input logic [31:0] k, input logic [31:0] imm,
                          input logic [31:0] exp_res, input logic exp_jump);
        drive(t, j, k, imm, 4'd7);
        step();
        alu_en = 1'b0;
        check({tag, "_rdy"}, {31'd0, alu_rdy}, 32'd1);
        check({tag, "_res"}, alu_result, exp_res);
        check({tag, "_jmp"}, {31'd0, alu_set_jump_addr}, {31'd0, exp_jump});
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 4'd0);
        alu_en = 1'b0;
        @(negedge clk_in);
        step();
        check("rst_rdy", {31'd0, alu_rdy}, 32'd0);
        check("rst_id",  {28'd0, alu_rob_id_out}, 32'd0);
        check("rst_res", alu_result, 32'd0);
        check("rst_jmp", {31'd0, alu_set_jump_addr}, 32'd0);
        rst_in = 1'b0;

        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 4'd3);
        step();
        alu_en = 1'b0;
        check("add_rdy", {31'd0, alu_rdy}, 32'd1);
        check("add_res", alu_result, 32'd12);
        check("add_id",  {28'd0, alu_rob_id_out}, 32'd3);
        check("add_jmp", {31'd0, alu_set_jump_addr}, 32'd0);
        step();
        check("add_pulse", {31'd0, alu_rdy}, 32'd0);

        run_op("sra",   ALU_SRA,   32'h8000_0000, 32'h24, 32'h0,    32'hF800_0000, 1'b0);
        run_op("srl",   ALU_SRL,   32'h8000_0000, 32'h24, 32'h0,    32'h0800_0000, 1'b0);
        run_op("srai",  ALU_SRAI,  32'h8000_0000, 32'h0,  32'h24,   32'hF800_0000, 1'b0);
        run_op("sltu",  ALU_SLTU,  32'hFFFF_FFFF, 32'd1,  32'h0,    32'd0,         1'b0);
        run_op("slt",   ALU_SLT,   32'hFFFF_FFFF, 32'd1,  32'h0,    32'd1,         1'b0);
        run_op("addw",  ALU_ADD,   32'hFFFF_FFFF, 32'd1,  32'h0,    32'd0,         1'b0);
        run_op("sub",   ALU_SUB,   32'd5,         32'd7,  32'h0,    32'hFFFF_FFFE, 1'b0);
        run_op("andi",  ALU_ANDI,  32'hF0F0_1234, 32'h0,  32'hFF,   32'h0000_0034, 1'b0);
        run_op("blt",   ALU_BLT,   32'hFFFF_FFFF, 32'd1,  32'h1000, 32'h1000,      1'b1);
        run_op("bltu",  ALU_BLTU,  32'hFFFF_FFFF, 32'd1,  32'h1000, 32'd0,         1'b0);
        run_op("bgeu",  ALU_BGEU,  32'hFFFF_FFFF, 32'd1,  32'h2000, 32'h2000,      1'b1);
        run_op("beq",   ALU_BEQ,   32'd9,         32'd9,  32'h3000, 32'h3000,      1'b1);
        run_op("jalr",  ALU_JALR,  32'h1003,      32'h0,  32'd4,    32'h1006,      1'b1);
        run_op("undef", 5'h1F,     32'd5,         32'd7,  32'h40,   32'd0,         1'b0);

        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 4'd1);
        step();
        check("strm1_rdy", {31'd0, alu_rdy}, 32'd1);
        check("strm1_id",  {28'd0, alu_rob_id_out}, 32'd1);
        drive(ALU_JALR, 32'h100, 32'd0, 32'd0, 4'd2);
        step();
        check("strm2_rdy", {31'd0, alu_rdy}, 32'd1);
        check("strm2_id",  {28'd0, alu_rob_id_out}, 32'd2);
        check("strm2_jmp", {31'd0, alu_set_jump_addr}, 32'd1);
        drive(ALU_ADD, 32'd3, 32'd3, 32'd0, 4'd3);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        alu_en = 1'b0;
        check("flush_rdy", {31'd0, alu_rdy}, 32'd0);
        check("flush_jmp", {31'd0, alu_set_jump_addr}, 32'd0);
        step();
        check("post_flush_rdy", {31'd0, alu_rdy}, 32'd0);

        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 4'd5);
        step();
        drive(ALU_SUB, 32'd100, 32'd1, 32'd0, 4'd9);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rdy", {31'd0, alu_rdy}, 32'd1);
            check("hold_res", alu_result, 32'd12);
            check("hold_id",  {28'd0, alu_rob_id_out}, 32'd5);
        end
        rdy_in = 1'b1;
        alu_en = 1'b0;
        step();
        check("unhold_rdy", {31'd0, alu_rdy}, 32'd0);

        drive(ALU_JALR, 32'h1003, 32'd0, 32'd4, 4'd6);
        step();
        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 4'd4);
        rst_in = 1'b1;
        step();
        check("mrst_rdy", {31'd0, alu_rdy}, 32'd0);
        check("mrst_id",  {28'd0, alu_rob_id_out}, 32'd0);
        check("mrst_res", alu_result, 32'd0);
        check("mrst_jmp", {31'd0, alu_set_jump_addr}, 32'd0);
        rst_in = 1'b0;
        alu_en = 1'b0;
        step();
        check("mrst_after_rdy", {31'd0, alu_rdy}, 32'd0);
        check("mrst_after_res", alu_result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
